// File: rtl/sprite_ram_loader.sv
// MMIO loader that serializes packed 32-bit pixel words or fill commands into
// the write port of a sprite bitmap RAM, one pixel per clock.
module sprite_ram_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  write,
    input  logic                  read,
    input  logic [4:0]            reg_addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy
);

    localparam int PPW = 32 / DATA_WIDTH;
    localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_FILL
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_fill_addr;
    logic [31:0]           r_shift;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_color;
    logic                  r_overrun;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;

    logic w_wr;
    logic w_wr_ptr;
    logic w_wr_data;
    logic w_wr_fill;
    logic w_wr_clr;
    logic w_busy;
    logic w_unused;

    assign w_wr      = cs & write;
    assign w_wr_ptr  = w_wr && (reg_addr == 5'd0);
    assign w_wr_data = w_wr && (reg_addr == 5'd1);
    assign w_wr_fill = w_wr && (reg_addr == 5'd2);
    assign w_wr_clr  = w_wr && (reg_addr == 5'd3);
    assign w_busy    = (r_state != S_IDLE);
    assign w_unused  = read;

    // The first pixel is issued on the accepting edge so that the registered
    // write port lines up with busy; the state machine covers the remainder.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register below sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_fill_addr <= '0;
            r_shift     <= '0;
            r_count     <= '0;
            r_color     <= '0;
            r_overrun   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            r_ram_we <= 1'b0;

            if (w_wr_clr) begin
                r_overrun <= 1'b0;
            end else if (w_busy && (w_wr_ptr || w_wr_data || w_wr_fill)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr_ptr) begin
                        r_ptr <= wr_data[ADDR_WIDTH-1:0];
                    end else if (w_wr_data) begin
                        r_shift    <= wr_data >> DATA_WIDTH;
                        r_count    <= '0;
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_ptr;
                        r_ram_din  <= wr_data[DATA_WIDTH-1:0];
                        r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                        r_state    <= S_UNPACK;
                    end else if (w_wr_fill) begin
                        r_color     <= wr_data[DATA_WIDTH-1:0];
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= '0;
                        r_ram_din   <= wr_data[DATA_WIDTH-1:0];
                        r_fill_addr <= ADDR_WIDTH'(1);
                        r_state     <= S_FILL;
                    end
                end
                S_UNPACK: begin
                    if (r_count == CW'(PPW - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_ptr;
                        r_ram_din  <= r_shift[DATA_WIDTH-1:0];
                        r_shift    <= r_shift >> DATA_WIDTH;
                        r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                        r_count    <= r_count + CW'(1);
                    end
                end
                S_FILL: begin
                    // Fill address wrapping back to zero means the whole RAM is covered.
                    if (r_fill_addr == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_fill_addr;
                        r_ram_din   <= r_color;
                        r_fill_addr <= r_fill_addr + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data    = {r_overrun, w_busy, {(30 - ADDR_WIDTH){1'b0}}, r_ptr};
    assign ram_we     = r_ram_we;
    assign ram_addr_w = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign busy       = w_busy;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: expected RAM writes are queued as
// stimulus is issued and popped as the DUT drives its write port.
module tb_sprite_ram_loader;

    localparam int AW    = 10;
    localparam int DW    = 2;
    localparam int PPW   = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [4:0]    reg_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_din;
    logic          busy;

    always #5 clk = ~clk;

    sprite_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .write      (write),
        .read       (read),
        .reg_addr   (reg_addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .busy       (busy)
    );

    // Simple dual-port bitmap RAM with a registered read port.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] rd_a = '0;
    logic [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr_w] <= ram_din;
        rd_q <= ram[rd_a];
    end

    logic [AW+DW-1:0] exp_q [$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               wr_cnt = 0;
    int               busy_cnt = 0;
    logic [AW-1:0]    m_ptr = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (ram_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_we", 32'(ram_we), 32'd0);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_q.pop_front();
                    check("ram_write", 32'({ram_addr_w, ram_din}), 32'(e));
                end
            end
        end
    end

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1;
        write = 1'b1;
        reg_addr = a;
        wr_data = d;
        @(negedge clk);
        cs = 1'b0;
        write = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < PPW; i++) begin
            exp_q.push_back({m_ptr, w[DW*i +: DW]});
            m_ptr = m_ptr + AW'(1);
        end
    endtask

    task automatic push_fill(input logic [DW-1:0] color);
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] a;
            a = AW'(i);
            exp_q.push_back({a, color});
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            w0;
        int            bad;
        logic [AW-1:0] start2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(ram_addr_w), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        rst_n = 1'b1;

        // PTR = 0x010, DATA = 0xE4E4_E4E4
        bus_wr(5'd0, 32'h0000_0010);
        m_ptr = 10'h010;
        check("ptr_readback", rd_data, 32'h0000_0010);
        push_word(32'hE4E4_E4E4);
        busy_cnt = 0;
        bus_wr(5'd1, 32'hE4E4_E4E4);
        check("first_we", 32'(ram_we), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
        wait_idle(100);
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("data_drained", 32'(exp_q.size()), 32'd0);
        check("ptr_after_data", rd_data, 32'h0000_0020);

        // Wrap 0x3F8 -> 0x007
        bus_wr(5'd0, 32'h0000_03F8);
        m_ptr = 10'h3F8;
        push_word(32'hFFFF_FFFF);
        bus_wr(5'd1, 32'hFFFF_FFFF);
        wait_idle(100);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("ptr_after_wrap", rd_data, 32'h0000_0008);

        // FILL color 2 (upper write-data bits must be ignored)
        push_fill(2'd2);
        busy_cnt = 0;
        bus_wr(5'd2, 32'hABCD_0006);
        wait_idle(2000);
        check("fill_busy_cycles", 32'(busy_cnt), 32'd1024);
        check("fill_drained", 32'(exp_q.size()), 32'd0);
        check("ptr_after_fill", rd_data, 32'h0000_0008);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            rd_a = AW'(a);
            @(negedge clk);
            if (rd_q !== 2'd2) bad++;
        end
        check("fill_readback_bad", 32'(bad), 32'd0);

        // Overrun: second DATA three cycles after the first
        w0 = wr_cnt;
        push_word(32'h1234_5678);
        bus_wr(5'd1, 32'h1234_5678);
        @(negedge clk);
        bus_wr(5'd1, 32'h9999_9999);
        wait_idle(100);
        check("overrun_wr_count", 32'(wr_cnt - w0), 32'd16);
        check("overrun_drained", 32'(exp_q.size()), 32'd0);
        check("overrun_set", rd_data, 32'h8000_0000 | 32'(m_ptr));
        bus_wr(5'd3, 32'd0);
        check("overrun_clr", rd_data, 32'(m_ptr));

        // Back-to-back: DATA in N+16 is dropped
        push_word(32'hA5A5_0F0F);
        bus_wr(5'd1, 32'hA5A5_0F0F);
        repeat (14) @(negedge clk);
        bus_wr(5'd1, 32'h5555_5555);
        check("b2b16_busy", 32'(busy), 32'd0);
        check("b2b16_we", 32'(ram_we), 32'd0);
        check("b2b16_overrun", rd_data, 32'h8000_0000 | 32'(m_ptr));
        check("b2b16_drained", 32'(exp_q.size()), 32'd0);
        bus_wr(5'd3, 32'd0);

        // Back-to-back: DATA in N+17 is accepted, pixels start in N+18
        push_word(32'h0123_4567);
        bus_wr(5'd1, 32'h0123_4567);
        repeat (15) @(negedge clk);
        start2 = m_ptr;
        push_word(32'hFEDC_BA98);
        bus_wr(5'd1, 32'hFEDC_BA98);
        check("b2b17_we", 32'(ram_we), 32'd1);
        check("b2b17_addr", 32'(ram_addr_w), 32'(start2));
        check("b2b17_status", rd_data, 32'h4000_0000 | (32'(start2) + 32'd1));
        wait_idle(100);
        check("b2b17_drained", 32'(exp_q.size()), 32'd0);
        check("b2b17_ptr", rd_data, 32'(m_ptr));

        // Reset mid-FILL aborts with no further writes
        push_fill(2'd1);
        bus_wr(5'd2, 32'h0000_0001);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_rd_data", rd_data, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(ram_addr_w), 32'd0);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("postrst_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("postrst_rd_data", rd_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_ram_loader.md
# sprite_ram_loader

Write-side companion to the goalpost/sprite bitmap RAMs: a MicroBlaze-visible MMIO slot that takes 32-bit packed pixel words or fill commands from software and serializes them into the RAM's write port (`we`/`addr_w`/`din`), one pixel per clock. It lets software redraw or recolor a sprite bitmap at run time while the video path keeps reading through the RAM's independent read port.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, bitmap RAM address bits (depth 2**ADDR_WIDTH)
- `DATA_WIDTH`, 2, bits per pixel; must divide 32; pixels per word PPW = 32/DATA_WIDTH (16 at default)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `cs`  in  1  slot chip select
- `write`  in  1  bus write strobe (qualified by `cs`)
- `read`  in  1  bus read strobe (unused internally; reads are side-effect free)
- `reg_addr`  in  5  register index
- `wr_data`  in  32  bus write data
- `rd_data`  out  32  bus read data
- `ram_we`  out  1  RAM write enable
- `ram_addr_w`  out  ADDR_WIDTH  RAM write address
- `ram_din`  out  DATA_WIDTH  RAM write data
- `busy`  out  1  loader is unpacking or filling

## Operation
- Bus write accepted when `cs & write`. Registers:
  - 0 PTR: `ptr <= wr_data[ADDR_WIDTH-1:0]`
  - 1 DATA: latch word into shift register, enter UNPACK
  - 2 FILL: latch color `wr_data[DATA_WIDTH-1:0]`, enter FILL
  - 3 CLR: clear sticky `overrun`
- Reads (combinational, any `reg_addr`): `rd_data = {overrun, busy, zeros, ptr}`; `overrun` is bit 31, `busy` is bit 30, `ptr` is bits ADDR_WIDTH-1:0.
- FSM states: IDLE, UNPACK, FILL.
  - IDLE: accepts writes to all registers. DATA -> UNPACK with count 0. FILL -> FILL with fill address 0.
  - UNPACK: each cycle, write pixel = shift register bits DATA_WIDTH-1:0 at `ptr`, then shift right by DATA_WIDTH, increment `ptr`. Exit to IDLE after PPW pixels.
  - FILL: each cycle, write the latched color at the fill address and increment it. Exit to IDLE after 2**ADDR_WIDTH writes. `ptr` is unchanged by FILL.
- Pixels go out LSB-first: `wr_data[1:0]` lands at the starting `ptr`, `wr_data[31:30]` at ptr+15.
- `ptr` and the fill address wrap modulo 2**ADDR_WIDTH (1023 -> 0).
- Writes to PTR, DATA or FILL while `busy` are dropped and set `overrun`.
  - CLR is always honoured, even while `busy`.
  - CLR in the same cycle that an overrun is being set: clear wins.
- `busy = (state != IDLE)`.
- `ram_we`, `ram_addr_w`, `ram_din` are registered; they change only on `clk` edges.
- Reset (async, `rst_n` low): state IDLE, `ptr` 0, shift register 0, count 0, `overrun` 0, `ram_we` 0, `ram_addr_w` 0, `ram_din` 0, `busy` 0.
  - Reset mid-UNPACK or mid-FILL aborts immediately. Pixels already written stay in RAM; no further RAM write occurs.

## Timing
- DATA write in cycle N:
  - `busy` high in cycles N+1 .. N+PPW.
  - `ram_we` high in cycles N+1 .. N+PPW with consecutive addresses.
  - `busy` low at N+PPW+1.
  - First cycle a new DATA write is accepted: N+PPW+1. A write in N+PPW is dropped.
- FILL write in cycle N: `ram_we` high in N+1 .. N+2**ADDR_WIDTH (1024 cycles at default).
- `ram_we` is never asserted in IDLE.
- Throughput: one pixel per cycle. Back-to-back DATA words with polling sustain PPW pixels per PPW+1 cycles.
- RAM read-port latency is unaffected. A pixel written in cycle K is visible on the RAM's `dout` for a read issued in cycle K+1 or later.

## Test plan
- Reset then readback: assert `rst_n` low mid-FILL, release.
  - Required: `rd_data` = 0; `ram_we` = 0 from the reset assertion onward.
  - Required: no RAM write after reset.
- PTR = 0x010, then DATA = 0xE4E4_E4E4.
  - Required: 16 writes at addresses 0x010..0x01F, data 0,1,2,3 repeating.
  - Required: `ptr` reads 0x020 afterwards; `busy` high exactly 16 cycles.
- Wrap: PTR = 0x3F8, then DATA = 0xFFFF_FFFF.
  - Required: writes of 3 at 0x3F8..0x3FF, then 0x000..0x007; `ptr` ends at 0x008.
- FILL with color 2.
  - Required: 1024 consecutive writes of 2 at addresses 0..1023; `ptr` unchanged.
  - Required: RAM readback through the read port returns 2 everywhere.
- Overrun: issue DATA, then another DATA write 3 cycles later.
  - Required: second word dropped (only 16 RAM writes total); status bit 31 = 1.
  - Then write CLR: bit 31 = 0.
- Back-to-back boundary: second DATA write in cycle N+16 is dropped (overrun set). The same write in cycle N+17 is accepted and its pixels start at N+18.
